// File: rtl/saradc_sample_fifo.sv
// SAR ADC capture stage: synchronizes the ADC done flag, optionally averages 2^k samples,
// buffers averages in a FIFO and exposes control/status/data over a Wishbone slave port.
module saradc_sample_fifo #(
  parameter int RES_W      = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [RES_W-1:0] adc_result,
  input  logic             adc_valid,
  output logic             adc_en,
  output logic             adc_cal,
  output logic             irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ACC_W = RES_W + 3;

  logic             ack_reg, en_reg, cal_reg, ovf_reg, irq_reg, push_reg;
  logic [31:0]      dat_reg;
  logic [1:0]       avg_reg;
  logic [LVL_W-1:0] thresh_reg, wr_ptr_reg, rd_ptr_reg;
  logic [2:0]       sync_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [2:0]       cnt_reg;
  logic [RES_W-1:0] push_data_reg;
  logic [RES_W-1:0] mem [FIFO_DEPTH];

  logic        req, wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] byte_mask, ctrl_img, ctrl_wr, thresh_img, thresh_wr, status_img, data_img, rdata;
  logic        ctrl_we, thresh_we, ovf_clr, clr, acc_clr;
  logic [LVL_W-1:0] level;
  logic        empty, full, pop, push_ok, push_drop, fire, last;
  logic [ACC_W-1:0] sum, avg_shift;
  logic        unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign req     = wbs_stb_i & wbs_cyc_i & ~ack_reg;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];

  assign ctrl_img   = {26'b0, avg_reg, 2'b00, cal_reg, en_reg};
  assign thresh_img = {{(32-LVL_W){1'b0}}, thresh_reg};
  assign ctrl_wr    = (ctrl_img & ~byte_mask) | (wbs_dat_i & byte_mask);
  assign thresh_wr  = (thresh_img & ~byte_mask) | (wbs_dat_i & byte_mask);

  assign ctrl_we   = wr & (reg_sel == 2'd0);
  assign thresh_we = wr & (reg_sel == 2'd3);
  assign ovf_clr   = wr & (reg_sel == 2'd1) & wbs_sel_i[0] & wbs_dat_i[2];
  assign clr       = ctrl_we & ctrl_wr[2];
  // A partial sum is meaningless once N changes or the ADC is stopped.
  assign acc_clr   = clr | (ctrl_we & (ctrl_wr[5:4] != avg_reg)) | (ctrl_we & en_reg & ~ctrl_wr[0]);

  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign pop       = rd & (reg_sel == 2'd2) & ~empty;
  assign push_ok   = push_reg & ~clr & (~full | pop);
  assign push_drop = push_reg & ~clr & full & ~pop;

  assign fire      = sync_reg[1] & ~sync_reg[2] & en_reg;
  assign sum       = acc_reg + ACC_W'(adc_result);
  assign avg_shift = sum >> avg_reg;
  assign last      = ({1'b0, cnt_reg} == ((4'd1 << avg_reg) - 4'd1));

  always_comb begin
    status_img             = '0;
    status_img[0]          = empty;
    status_img[1]          = full;
    status_img[2]          = ovf_reg;
    status_img[LVL_W+7:8]  = level;
  end

  assign data_img = empty ? 32'd0 : {1'b1, {(31-RES_W){1'b0}}, mem[rd_ptr_reg[PTR_W-1:0]]};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata = ctrl_img;
      2'd1:    rdata = status_img;
      2'd2:    rdata = data_img;
      default: rdata = thresh_img;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data_reg;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
      en_reg        <= 1'b0;
      cal_reg       <= 1'b0;
      avg_reg       <= '0;
      thresh_reg    <= '0;
      ovf_reg       <= 1'b0;
      irq_reg       <= 1'b0;
      sync_reg      <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      ack_reg  <= req;
      dat_reg  <= rd ? rdata : 32'd0;
      sync_reg <= {sync_reg[1:0], adc_valid};
      if (ctrl_we) begin
        en_reg  <= ctrl_wr[0];
        cal_reg <= ctrl_wr[1];
        avg_reg <= ctrl_wr[5:4];
      end
      if (thresh_we) thresh_reg <= thresh_wr[LVL_W-1:0];
      if (push_drop)    ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
      irq_reg  <= ovf_reg | ((thresh_reg != '0) && (level >= thresh_reg));

      push_reg <= 1'b0;
      if (acc_clr) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (fire) begin
        if (last) begin
          push_reg      <= 1'b1;
          push_data_reg <= avg_shift[RES_W-1:0];
          acc_reg       <= '0;
          cnt_reg       <= '0;
        end else begin
          acc_reg <= sum;
          cnt_reg <= cnt_reg + 3'd1;
        end
      end

      if (clr) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign adc_en    = en_reg;
  assign adc_cal   = cal_reg;
  assign irq       = irq_reg;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], ctrl_wr[31:6], ctrl_wr[3],
                         thresh_wr[31:LVL_W], avg_shift[ACC_W-1:RES_W]};

endmodule

// File: tb/tb_saradc_sample_fifo.sv
// Scoreboard bench: a behavioural averaging/FIFO model queues expected DATA words as ADC
// pulses are driven; DATA reads pop and compare.
module tb_saradc_sample_fifo;
  localparam int RES_W = 10;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]       sel = 4'h0;
  logic [31:0]      adr = '0, wdat = '0;
  logic             ack;
  logic [31:0]      rdat;
  logic [RES_W-1:0] adc_result = '0;
  logic             adc_valid = 1'b0;
  logic             adc_en, adc_cal, irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  int  m_k = 0, m_acc = 0, m_cnt = 0;
  bit  m_en = 0, m_ovf = 0;

  saradc_sample_fifo #(.RES_W(RES_W), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .adc_result(adc_result), .adc_valid(adc_valid), .adc_en(adc_en), .adc_cal(adc_cal),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(exp_q.size()) << 8;
    s[0] = (exp_q.size() == 0);
    s[1] = (exp_q.size() == DEPTH);
    s[2] = m_ovf;
    return s;
  endfunction

  task automatic model_push(input int v);
    int avg;
    if (!m_en) return;
    m_acc += v;
    m_cnt++;
    if (m_cnt == (1 << m_k)) begin
      avg = m_acc >> m_k;
      if (exp_q.size() < DEPTH) exp_q.push_back(32'h8000_0000 | 32'(avg));
      else m_ovf = 1;
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    bit seen;
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    seen = 0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(posedge clk); #1;
      if (ack) seen = 1;
    end
    r = rdat;
    stb = 0; cyc = 0; we = 0;
    chk("ack_seen", 32'(seen), 32'd1);
    $display("xfer we=%0d adr=%h wdat=%h sel=%h rdat=%h", w, a, d, s, r);
    @(posedge clk); #1;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic [31:0] r;
    int nk;
    wb_xfer(1'b1, 32'h0, v, 4'hF, r);
    nk = int'(v[5:4]);
    if (nk != m_k || (m_en && !v[0]) || v[2]) begin
      m_acc = 0;
      m_cnt = 0;
    end
    if (v[2]) exp_q.delete();
    m_en = v[0];
    m_k  = nk;
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, 4'hF, r);
    chk(tag, r, exp);
  endtask

  task automatic rd_data();
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    rd_reg("data", 32'h8, e);
  endtask

  task automatic adc_pulse(input int v);
    @(negedge clk);
    adc_result = RES_W'(v);
    adc_valid  = 1;
    model_push(v);
    repeat (3) @(negedge clk);
    adc_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] e;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_en", 32'(adc_en), 0);
    chk("rst_cal", 32'(adc_cal), 0);
    chk("rst_ack", 32'(ack), 0);
    stb = 1; cyc = 1; we = 0; adr = 32'h4; sel = 4'hF;
    @(posedge clk); #1;
    chk("ack_first", 32'(ack), 1);
    chk("status_rst", rdat, 32'h1);
    @(posedge clk); #1;
    chk("ack_drop", 32'(ack), 0);
    chk("dat_idle", rdat, 0);
    @(negedge clk); stb = 0; cyc = 0;
    rd_reg("ctrl_rst", 32'h0, 32'h0);
    rd_reg("data_rst", 32'h8, 32'h0);
    rd_reg("thresh_rst", 32'hC, 32'h0);

    // 2: single samples
    wr_ctrl(32'h03);
    chk("cal_on", 32'(adc_cal), 1);
    wr_ctrl(32'h01);
    chk("en_on", 32'(adc_en), 1);
    chk("cal_off", 32'(adc_cal), 0);
    adc_pulse(32'h155);
    adc_pulse(32'h2AA);
    rd_reg("status_lvl2", 32'h4, exp_status());
    rd_data();
    rd_data();
    rd_data();

    // 3: averaging by 4
    wr_ctrl(32'h21);
    adc_pulse(100); adc_pulse(101); adc_pulse(102); adc_pulse(104);
    rd_reg("status_avg", 32'h4, exp_status());
    rd_data();
    adc_pulse(100); adc_pulse(100); adc_pulse(100);
    rd_reg("status_partial", 32'h4, exp_status());

    // 4: overflow
    wr_ctrl(32'h01);
    for (int i = 0; i <= DEPTH; i++) adc_pulse(i * 37 + 5);
    rd_reg("status_ovf", 32'h4, exp_status());
    chk("irq_ovf", 32'(irq), 1);
    wb_xfer(1'b1, 32'h4, 32'h4, 4'h1, r);
    m_ovf = 0;
    rd_reg("status_w1c", 32'h4, exp_status());
    chk("irq_w1c", 32'(irq), 0);

    // 6a: push landing on the same edge as a pop of a full FIFO
    @(negedge clk);
    adc_result = 10'h3C3;
    adc_valid  = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = 32'h8; sel = 4'hF;
    @(posedge clk); #1;
    chk("coinc_ack", 32'(ack), 1);
    r = rdat;
    stb = 0; cyc = 0;
    e = exp_q.pop_front();
    chk("coinc_data", r, e);
    model_push(32'h3C3);
    $display("xfer coincident pop rdat=%h", r);
    repeat (3) @(negedge clk);
    adc_valid = 0;
    repeat (3) @(negedge clk);
    rd_reg("status_coinc", 32'h4, exp_status());
    for (int i = 0; i <= DEPTH; i++) rd_data();

    // 5: level threshold interrupt
    wb_xfer(1'b1, 32'hC, 32'h3, 4'hF, r);
    adc_pulse(11);
    adc_pulse(22);
    chk("irq_lvl2", 32'(irq), 0);
    @(negedge clk);
    adc_result = 10'd33;
    adc_valid  = 1;
    model_push(33);
    repeat (4) @(posedge clk); #1;
    chk("irq_push_edge", 32'(irq), 0);
    @(posedge clk); #1;
    chk("irq_lvl3", 32'(irq), 1);
    @(negedge clk); adc_valid = 0;
    repeat (3) @(negedge clk);
    rd_data();
    chk("irq_after_pop", 32'(irq), 0);
    wb_xfer(1'b1, 32'h0, 32'h0, 4'b0010, r);
    chk("en_sel_keep", 32'(adc_en), 1);
    rd_reg("ctrl_sel_keep", 32'h0, 32'h01);

    // CLR empties the FIFO and reads back as 0
    wr_ctrl(32'h05);
    rd_reg("status_clr", 32'h4, exp_status());
    rd_reg("ctrl_clr_rd", 32'h0, 32'h01);

    // 6b: reset while an ack is pending
    adc_pulse(44);
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; adr = 32'hC; wdat = 32'h7; sel = 4'hF;
    @(posedge clk); #1;
    chk("pend_ack", 32'(ack), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_ack_drop", 32'(ack), 0);
    chk("rst_en_mid", 32'(adc_en), 0);
    stb = 0; cyc = 0; we = 0;
    @(negedge clk); rst = 0;
    exp_q.delete();
    m_en = 0; m_k = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    rd_reg("ctrl_rst2", 32'h0, 32'h0);
    rd_reg("status_rst2", 32'h4, exp_status());
    rd_reg("thresh_rst2", 32'hC, 32'h0);
    rd_data();
    chk("irq_rst2", 32'(irq), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
